// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router slice.
package router_pkg;

    localparam int ROUTER_NUM_PORTS = 3;
    localparam int TIMEOUT_DEFAULT  = 30;

    typedef logic [1:0] addr_t;

    localparam addr_t ADDR_INVALID = 2'b11;

    // One-hot FIFO select for an address; the invalid address selects nothing.
    function automatic logic [ROUTER_NUM_PORTS-1:0] addr_onehot(input addr_t addr);
        logic [ROUTER_NUM_PORTS-1:0] sel;
        sel = '0;
        if (addr != ADDR_INVALID) begin
            sel[addr] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/router_sync_if.sv
// Router FSM / output FIFO bundle seen by router_sync.
// Optional feature macro: ROUTER_SYNC_ADDR_ERR_EN (adds addr_err).
interface router_sync_if;
    import router_pkg::*;

    logic                        detect_add;
    addr_t                       data_in;
    logic                        write_enb_reg;
    logic                        read_enb_0;
    logic                        read_enb_1;
    logic                        read_enb_2;
    logic                        empty_0;
    logic                        empty_1;
    logic                        empty_2;
    logic                        full_0;
    logic                        full_1;
    logic                        full_2;
    logic [ROUTER_NUM_PORTS-1:0] write_enb;
    logic                        fifo_full;
    logic                        vld_out_0;
    logic                        vld_out_1;
    logic                        vld_out_2;
    logic                        soft_reset_0;
    logic                        soft_reset_1;
    logic                        soft_reset_2;
`ifdef ROUTER_SYNC_ADDR_ERR_EN
    logic                        addr_err;
`endif

    // FSM, FIFOs and readers drive the inputs and observe the results.
    modport master (
`ifdef ROUTER_SYNC_ADDR_ERR_EN
        input  addr_err,
`endif
        output detect_add, data_in, write_enb_reg,
        output read_enb_0, read_enb_1, read_enb_2,
        output empty_0, empty_1, empty_2,
        output full_0, full_1, full_2,
        input  write_enb, fifo_full,
        input  vld_out_0, vld_out_1, vld_out_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2
    );

    // The synchronizer itself.
    modport slave (
`ifdef ROUTER_SYNC_ADDR_ERR_EN
        output addr_err,
`endif
        input  detect_add, data_in, write_enb_reg,
        input  read_enb_0, read_enb_1, read_enb_2,
        input  empty_0, empty_1, empty_2,
        input  full_0, full_1, full_2,
        output write_enb, fifo_full,
        output vld_out_0, vld_out_1, vld_out_2,
        output soft_reset_0, soft_reset_1, soft_reset_2
    );

endinterface

// File: rtl/router_sync_timer.sv
// Per-port read-stall timer: after TIMEOUT consecutive cycles of valid data
// that nobody reads, pulses soft_reset for one cycle and starts counting again.
module router_sync_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT, // >= 2
    parameter int CNT_W   = 5                // 2**CNT_W >= TIMEOUT
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    logic [CNT_W-1:0] cnt;
    logic             stall;

    assign stall = vld && !rd;

    // Count stall cycles; the TIMEOUT-th one wraps the count and fires the pulse.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (stall && cnt == CNT_W'(TIMEOUT - 1)) begin
            cnt        <= '0;
            soft_reset <= 1'b1;
        end else if (stall) begin
            cnt        <= cnt + 1'b1;
            soft_reset <= 1'b0;
        end else begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/router_sync.sv
// Router synchronizer: latches the header address, steers the FSM write
// strobe to one FIFO, returns its full flag, drives valid_out and times out
// unread ports.
// Optional feature macro: ROUTER_SYNC_ADDR_ERR_EN (registered addr_err pulse
// after a header carrying the invalid address).
module router_sync
    import router_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 5
) (
    input  logic          clock,
    input  logic          resetn,
    router_sync_if.slave  bus
);

    addr_t addr_q;

    // Header address latch; a header cycle still decodes with the previous address.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr_q <= ADDR_INVALID;
        end else if (bus.detect_add) begin
            addr_q <= bus.data_in;
        end
    end

    // Write steering and full-flag return for the selected FIFO.
    always_comb begin
        // NOTE: defaults first so no path through the block leaves an output unassigned (no latch).
        bus.write_enb = '0;
        bus.fifo_full = 1'b0;
        if (bus.write_enb_reg) begin
            bus.write_enb = addr_onehot(addr_q);
        end
        case (addr_q)
            2'd0:    bus.fifo_full = bus.full_0;
            2'd1:    bus.fifo_full = bus.full_1;
            2'd2:    bus.fifo_full = bus.full_2;
            default: bus.fifo_full = 1'b0;
        endcase
    end

    assign bus.vld_out_0 = ~bus.empty_0;
    assign bus.vld_out_1 = ~bus.empty_1;
    assign bus.vld_out_2 = ~bus.empty_2;

    router_sync_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_0 (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (bus.vld_out_0),
        .rd         (bus.read_enb_0),
        .soft_reset (bus.soft_reset_0)
    );

    router_sync_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_1 (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (bus.vld_out_1),
        .rd         (bus.read_enb_1),
        .soft_reset (bus.soft_reset_1)
    );

    router_sync_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer_2 (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (bus.vld_out_2),
        .rd         (bus.read_enb_2),
        .soft_reset (bus.soft_reset_2)
    );

`ifdef ROUTER_SYNC_ADDR_ERR_EN
    // One-cycle error flag following a header with the invalid address.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            bus.addr_err <= 1'b0;
        end else begin
            bus.addr_err <= bus.detect_add && (bus.data_in == ADDR_INVALID);
        end
    end
`endif

endmodule
